// File: rtl/router_sync_multi.sv
// Synchroniser between the router FSM, the register block and NUM_CH output FIFOs:
// address latch and decode, full-flag mux, per-channel valid and read-timeout soft reset.
module router_sync_multi #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 30,
  parameter int CNT_W   = 5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] read_enb,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] full,
  input  logic              status_clr,
  output logic [NUM_CH-1:0] write_enb,
  output logic              fifo_full,
  output logic              addr_err,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] soft_reset,
  output logic [NUM_CH-1:0] timeout_flag
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_cnt [NUM_CH];
  logic [NUM_CH-1:0] r_soft_reset;
  logic [NUM_CH-1:0] r_timeout_flag;

  logic [NUM_CH-1:0] w_sel;
  logic [NUM_CH-1:0] w_starved;
  logic [NUM_CH-1:0] w_expire;

  // Write handshake: a FIFO write happens in a cycle where write_enb_reg (valid) is high
  // and the addressed channel exists; the FSM samples fifo_full as its ready (inverted).
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_sel[i] = (r_addr == ADDR_W'(i));
    end
  end

  // An out-of-range address matches no channel, so it selects nothing and reads no full flag.
  assign addr_err  = ~|w_sel;
  assign write_enb = write_enb_reg ? w_sel : '0;
  assign fifo_full = |(w_sel & full);
  assign vld_out   = ~empty;

  always_comb begin
    w_starved = '0;
    w_expire  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_starved[i] = vld_out[i] & ~read_enb[i];
      w_expire[i]  = w_starved[i] & (r_cnt[i] == LP_CNT_LAST);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_addr <= '0;
    end else if (detect_add) begin
      r_addr <= data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_cnt[i] <= '0;
      end
      r_soft_reset <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!w_starved[i] || w_expire[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
      r_soft_reset <= w_expire;
    end
  end

  // A timeout on the same edge as status_clr leaves its flag set.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_timeout_flag <= '0;
    end else if (status_clr) begin
      r_timeout_flag <= w_expire;
    end else begin
      r_timeout_flag <= r_timeout_flag | w_expire;
    end
  end

  assign soft_reset   = r_soft_reset;
  assign timeout_flag = r_timeout_flag;

endmodule

// File: tb/tb_router_sync_multi.sv
// Directed bench for router_sync_multi: address decode, invalid address, timeouts,
// sticky status with clear, and reset mid-timeout.
module tb_router_sync_multi;

  localparam int NUM_CH  = 3;
  localparam int ADDR_W  = 2;
  localparam int TIMEOUT = 30;
  localparam int CNT_W   = 5;

  logic              clock;
  logic              resetn;
  logic              detect_add;
  logic [ADDR_W-1:0] data_in;
  logic              write_enb_reg;
  logic [NUM_CH-1:0] read_enb;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic              status_clr;
  logic [NUM_CH-1:0] write_enb;
  logic              fifo_full;
  logic              addr_err;
  logic [NUM_CH-1:0] vld_out;
  logic [NUM_CH-1:0] soft_reset;
  logic [NUM_CH-1:0] timeout_flag;

  int n_cmp = 0;
  int n_err = 0;

  router_sync_multi #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .detect_add   (detect_add),
    .data_in      (data_in),
    .write_enb_reg(write_enb_reg),
    .read_enb     (read_enb),
    .empty        (empty),
    .full         (full),
    .status_clr   (status_clr),
    .write_enb    (write_enb),
    .fifo_full    (fifo_full),
    .addr_err     (addr_err),
    .vld_out      (vld_out),
    .soft_reset   (soft_reset),
    .timeout_flag (timeout_flag)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    detect_add    = 1'b0;
    data_in       = '0;
    write_enb_reg = 1'b0;
    read_enb      = '0;
    empty         = '1;
    full          = '0;
    status_clr    = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    full   = 3'b001;
    #1;
    n_cmp++;
    if (soft_reset !== 3'b000) begin
      n_err++; $display("FAIL reset_soft_reset got=%b exp=%b", soft_reset, 3'b000);
    end
    n_cmp++;
    if (timeout_flag !== 3'b000) begin
      n_err++; $display("FAIL reset_timeout_flag got=%b exp=%b", timeout_flag, 3'b000);
    end
    n_cmp++;
    if (addr_err !== 1'b0) begin
      n_err++; $display("FAIL reset_addr_err got=%b exp=%b", addr_err, 1'b0);
    end
    n_cmp++;
    if (fifo_full !== 1'b1) begin
      n_err++; $display("FAIL reset_fifo_full_ch0 got=%b exp=%b", fifo_full, 1'b1);
    end
    n_cmp++;
    if (write_enb !== 3'b000) begin
      n_err++; $display("FAIL reset_write_enb_idle got=%b exp=%b", write_enb, 3'b000);
    end
    n_cmp++;
    if (vld_out !== 3'b000) begin
      n_err++; $display("FAIL reset_vld_out got=%b exp=%b", vld_out, 3'b000);
    end
    full = '0;
  endtask

  task automatic test_addr_decode();
    // latch 2 with a write in the same cycle: decode still uses old address 0
    detect_add    = 1'b1;
    data_in       = 2'd2;
    write_enb_reg = 1'b1;
    #1;
    n_cmp++;
    if (write_enb !== 3'b001) begin
      n_err++; $display("FAIL decode_old_addr got=%b exp=%b", write_enb, 3'b001);
    end
    tick();
    detect_add = 1'b0;
    full       = 3'b011;
    #1;
    n_cmp++;
    if (write_enb !== 3'b100) begin
      n_err++; $display("FAIL decode_addr2 got=%b exp=%b", write_enb, 3'b100);
    end
    n_cmp++;
    if (fifo_full !== 1'b0) begin
      n_err++; $display("FAIL full_mux_ch2_clear got=%b exp=%b", fifo_full, 1'b0);
    end
    n_cmp++;
    if (addr_err !== 1'b0) begin
      n_err++; $display("FAIL addr2_addr_err got=%b exp=%b", addr_err, 1'b0);
    end
    full = 3'b100;
    #1;
    n_cmp++;
    if (fifo_full !== 1'b1) begin
      n_err++; $display("FAIL full_mux_ch2_set got=%b exp=%b", fifo_full, 1'b1);
    end
    write_enb_reg = 1'b0;
    #1;
    n_cmp++;
    if (write_enb !== 3'b000) begin
      n_err++; $display("FAIL decode_no_write got=%b exp=%b", write_enb, 3'b000);
    end
    tick();
    n_cmp++;
    if (write_enb !== 3'b000) begin
      n_err++; $display("FAIL decode_no_hold got=%b exp=%b", write_enb, 3'b000);
    end
    full = '0;
  endtask

  task automatic test_invalid_addr();
    detect_add = 1'b1;
    data_in    = 2'd3;
    tick();
    detect_add    = 1'b0;
    data_in       = 2'd1;
    write_enb_reg = 1'b1;
    full          = 3'b111;
    #1;
    n_cmp++;
    if (write_enb !== 3'b000) begin
      n_err++; $display("FAIL bad_addr_write_enb got=%b exp=%b", write_enb, 3'b000);
    end
    n_cmp++;
    if (fifo_full !== 1'b0) begin
      n_err++; $display("FAIL bad_addr_fifo_full got=%b exp=%b", fifo_full, 1'b0);
    end
    n_cmp++;
    if (addr_err !== 1'b1) begin
      n_err++; $display("FAIL bad_addr_addr_err got=%b exp=%b", addr_err, 1'b1);
    end
    // data_in changes without detect_add: address must hold
    tick();
    n_cmp++;
    if (addr_err !== 1'b1) begin
      n_err++; $display("FAIL bad_addr_hold got=%b exp=%b", addr_err, 1'b1);
    end
    detect_add = 1'b1;
    data_in    = 2'd0;
    tick();
    detect_add = 1'b0;
    #1;
    n_cmp++;
    if (addr_err !== 1'b0) begin
      n_err++; $display("FAIL addr0_addr_err got=%b exp=%b", addr_err, 1'b0);
    end
    n_cmp++;
    if (write_enb !== 3'b001) begin
      n_err++; $display("FAIL addr0_write_enb got=%b exp=%b", write_enb, 3'b001);
    end
    write_enb_reg = 1'b0;
    full          = '0;
  endtask

  task automatic test_timeout_single();
    logic [NUM_CH-1:0] exp_sr;
    empty = 3'b101;
    #1;
    n_cmp++;
    if (vld_out !== 3'b010) begin
      n_err++; $display("FAIL vld_out_ch1 got=%b exp=%b", vld_out, 3'b010);
    end
    for (int k = 1; k <= 32; k++) begin
      tick();
      exp_sr = (k == 30) ? 3'b010 : 3'b000;
      n_cmp++;
      if (soft_reset !== exp_sr) begin
        n_err++; $display("FAIL t1_soft_reset edge=%0d got=%b exp=%b", k, soft_reset, exp_sr);
      end
    end
    n_cmp++;
    if (timeout_flag !== 3'b010) begin
      n_err++; $display("FAIL t1_timeout_flag got=%b exp=%b", timeout_flag, 3'b010);
    end
    empty = '1;
    tick();
    n_cmp++;
    if (timeout_flag !== 3'b010) begin
      n_err++; $display("FAIL t1_flag_sticky got=%b exp=%b", timeout_flag, 3'b010);
    end
  endtask

  task automatic test_read_restart();
    logic [NUM_CH-1:0] exp_sr;
    empty = 3'b110;
    for (int k = 1; k <= 60; k++) begin
      read_enb = (k == 29) ? 3'b001 : 3'b000;
      tick();
      exp_sr = (k == 59) ? 3'b001 : 3'b000;
      n_cmp++;
      if (soft_reset !== exp_sr) begin
        n_err++; $display("FAIL t0_read_restart edge=%0d got=%b exp=%b", k, soft_reset, exp_sr);
      end
    end
    read_enb = '0;
    empty    = '1;
    tick();
    n_cmp++;
    if (timeout_flag !== 3'b011) begin
      n_err++; $display("FAIL t0_timeout_flag got=%b exp=%b", timeout_flag, 3'b011);
    end
  endtask

  task automatic test_dual_timeout_clear();
    logic [NUM_CH-1:0] exp_sr;
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    n_cmp++;
    if (timeout_flag !== 3'b000) begin
      n_err++; $display("FAIL clr_timeout_flag got=%b exp=%b", timeout_flag, 3'b000);
    end
    // read_enb on an empty channel must not disturb anything
    empty    = 3'b010;
    read_enb = 3'b010;
    for (int k = 1; k <= 31; k++) begin
      status_clr = (k == 30);
      tick();
      exp_sr = (k == 30) ? 3'b101 : 3'b000;
      n_cmp++;
      if (soft_reset !== exp_sr) begin
        n_err++; $display("FAIL dual_soft_reset edge=%0d got=%b exp=%b", k, soft_reset, exp_sr);
      end
      if (k == 30) begin
        n_cmp++;
        if (timeout_flag !== 3'b101) begin
          n_err++; $display("FAIL dual_flag_set_wins got=%b exp=%b", timeout_flag, 3'b101);
        end
      end
    end
    status_clr = 1'b0;
    read_enb   = '0;
    empty      = '1;
  endtask

  task automatic test_reset_mid_timeout();
    logic [NUM_CH-1:0] exp_sr;
    empty = 3'b101;
    for (int k = 1; k <= 20; k++) tick();
    resetn        = 1'b0;
    write_enb_reg = 1'b1;
    tick();
    resetn = 1'b1;
    n_cmp++;
    if (timeout_flag !== 3'b000) begin
      n_err++; $display("FAIL rst_mid_flag got=%b exp=%b", timeout_flag, 3'b000);
    end
    n_cmp++;
    if (write_enb !== 3'b001) begin
      n_err++; $display("FAIL rst_mid_addr0 got=%b exp=%b", write_enb, 3'b001);
    end
    write_enb_reg = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      tick();
      exp_sr = (k == 30) ? 3'b010 : 3'b000;
      n_cmp++;
      if (soft_reset !== exp_sr) begin
        n_err++; $display("FAIL rst_mid_soft_reset edge=%0d got=%b exp=%b", k, soft_reset, exp_sr);
      end
    end
    n_cmp++;
    if (timeout_flag !== 3'b010) begin
      n_err++; $display("FAIL rst_mid_flag_after got=%b exp=%b", timeout_flag, 3'b010);
    end
    empty = '1;
  endtask

  initial begin
    test_reset();
    test_addr_decode();
    test_invalid_addr();
    test_timeout_single();
    test_read_restart();
    test_dual_timeout_clear();
    test_reset_mid_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/router_sync_multi.md
Name: router_sync_multi

Overview:
- Parametrised synchroniser between the router FSM, the register block and NUM_CH output FIFOs.
- Latches the destination address of each packet and decodes FIFO write enables from it.
- Muxes the selected FIFO's full flag back to the FSM and generates per-channel valid outputs.
- Runs per-channel read-timeout counters that soft-reset a FIFO nobody drains. Adds two things the previous generation lacked: invalid-address detection and sticky timeout status with a clear input.

Parameters:
- NUM_CH, 3, number of output channels/FIFOs (1..8).
- ADDR_W, 2, width of data_in address field; 2**ADDR_W >= NUM_CH.
- TIMEOUT, 30, consecutive valid-but-unread cycles before soft reset (2..2**CNT_W).
- CNT_W, 5, width of each timeout counter.

Ports:
- clock  in  1  system clock, all state on rising edge
- resetn  in  1  synchronous, active-low reset
- detect_add  in  1  FSM strobe: data_in carries the header address this cycle
- data_in  in  ADDR_W  destination address field
- write_enb_reg  in  1  FSM permits a FIFO write this cycle
- read_enb  in  NUM_CH  per-channel read enables from the consumers
- empty  in  NUM_CH  per-FIFO empty flags
- full  in  NUM_CH  per-FIFO full flags
- status_clr  in  1  clears all sticky timeout_flag bits
- write_enb  out  NUM_CH  one-hot FIFO write enable
- fifo_full  out  1  full flag of the addressed FIFO
- addr_err  out  1  latched address is >= NUM_CH
- vld_out  out  NUM_CH  per-channel data valid
- soft_reset  out  NUM_CH  per-channel one-cycle FIFO flush pulse
- timeout_flag  out  NUM_CH  sticky: channel has timed out since last clear

Behaviour:
- Reset (resetn=0 at an edge) sets addr_q=0, all counters=0, soft_reset=0 and timeout_flag=0.
  - Reset overrides every other input.
  - Combinational outputs follow from addr_q=0.
- Address latch: if detect_add=1 at an edge, addr_q<=data_in; otherwise addr_q holds.
  - Decode always uses the registered addr_q. If detect_add and write_enb_reg are high in the same cycle, write_enb uses the old addr_q.
- write_enb (combinational):
  - write_enb_reg=1 and addr_q<NUM_CH: write_enb[addr_q]=1, all other bits 0.
  - Otherwise all bits 0. There is never a latch or a held value.
- fifo_full (combinational): full[addr_q] when addr_q<NUM_CH, else 0.
- addr_err (combinational): addr_q>=NUM_CH. Writes are suppressed while addr_err=1.
- vld_out[i] = ~empty[i], combinational.
- Timeout counter, per channel i, evaluated at each edge (not in reset):
  - vld_out[i]=0 or read_enb[i]=1: cnt<=0, soft_reset[i]<=0.
  - Else if cnt==TIMEOUT-1: cnt<=0, soft_reset[i]<=1, timeout_flag[i]<=1.
  - Else: cnt<=cnt+1, soft_reset[i]<=0.
- Timeout timing:
  - soft_reset[i] rises at the edge ending the TIMEOUT-th consecutive cycle with vld=1 and read=0.
  - It stays high exactly one cycle unless re-triggered; the next trigger needs a fresh TIMEOUT cycles.
  - A cycle in which soft_reset is high counts toward the next window if vld is still 1 and read is 0.
- Channels are fully independent. Simultaneous timeouts on several channels all pulse in the same cycle.
- timeout_flag:
  - status_clr=1 at an edge clears all bits.
  - If a timeout and status_clr coincide on a channel, set wins: the flag reads 1.
- read_enb[i]=1 while empty[i]=1 has no effect on any state (counter already 0).
- Counter width: CNT_W must hold TIMEOUT-1. No wrap is possible because the counter resets at TIMEOUT-1.

Test Plan:
- Reset, then detect_add=1 with data_in=2, then write_enb_reg=1 → write_enb=3'b100 from the cycle after latch; fifo_full tracks full[2]; addr_err=0.
- detect_add=1 with data_in=3 (NUM_CH=3), then write_enb_reg=1, full=3'b111 → write_enb=0, fifo_full=0, addr_err=1; latching data_in=0 afterwards clears addr_err.
- empty[1]=0, read_enb[1]=0 held for 30 cycles → soft_reset[1] is 1 for exactly one cycle after the 30th edge; timeout_flag[1]=1 and stays 1; other channels are 0.
- empty[0]=0, read_enb[0] pulsed at cycle 29 → no soft_reset; the counter restarts and soft_reset[0] fires 30 cycles after the pulse.
- Channels 0 and 2 starved simultaneously, with status_clr asserted on the same edge as the timeouts → both soft_reset bits pulse together; timeout_flag=3'b101.
- resetn=0 at counter=20 mid-timeout → counter=0 and flags cleared; a full 30 cycles are needed after release before soft_reset fires.
